// File: rtl/vma_mem_port.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vma_mem_port : VMA/MD memory-bus responder (req/ack handshake, NXM abort)  |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
module vma_mem_port #(
  parameter int ADDR_W  = 22,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [31:0]       vma_i,
  input  logic [31:0]       md_in_i,
  input  logic              memrd_i,
  input  logic              memwr_i,
  input  logic              nxm_clr_i,
  output logic              mem_req_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [31:0]       mem_rdata_i,
  output logic [31:0]       md_o,
  output logic              mem_done_o,
  output logic              busy_o,
  output logic              nxm_o
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic               req_q, req_d;
  logic               write_q, write_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        md_q, md_d;
  logic               done_q, done_d;
  logic               nxm_q, nxm_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               nxm_set;

  // Upper VMA bits are virtual-only and never reach the physical bus.
  generate
    if (ADDR_W < 32) begin : g_vma_unused
      logic unused_vma_hi;
      assign unused_vma_hi = ^vma_i[31:ADDR_W];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    md_d    = md_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    nxm_set = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (memwr_i || memrd_i) begin
          addr_d  = vma_i[ADDR_W-1:0];
          write_d = memwr_i;
          req_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_REQ;
          if (memwr_i) begin
            wdata_d = md_in_i;
          end
        end
      end
      S_REQ: begin
        // An ack on the last permitted cycle still completes the transfer.
        if (mem_ack_i) begin
          req_d   = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
          if (!write_q) begin
            md_d = mem_rdata_i;
          end
        end else if (cnt_q == C_CNT_LAST) begin
          req_d   = 1'b0;
          nxm_set = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase

    if (nxm_set) begin
      nxm_d = 1'b1;
    end else if (nxm_clr_i) begin
      nxm_d = 1'b0;
    end else begin
      nxm_d = nxm_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      md_q    <= '0;
      done_q  <= 1'b0;
      nxm_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      md_q    <= md_d;
      done_q  <= done_d;
      nxm_q   <= nxm_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_req_o   = req_q;
  assign mem_write_o = write_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign md_o        = md_q;
  assign mem_done_o  = done_q;
  assign busy_o      = (state_q == S_REQ);
  assign nxm_o       = nxm_q;

endmodule
`default_nettype wire

// File: tb/tb_vma_mem_port.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_vma_mem_port : directed vector bench for vma_mem_port (TIMEOUT = 4)     |
// | Revision        : 1.0                                                      |
// +----------------------------------------------------------------------------+
module tb_vma_mem_port;

  localparam int ADDR_W  = 22;
  localparam int TIMEOUT = 4;
  localparam int OUT_W   = 1 + 1 + ADDR_W + 32 + 32 + 1 + 1 + 1;

  logic              clk;
  logic              rst_n;
  logic [31:0]       vma;
  logic [31:0]       md_in;
  logic              memrd;
  logic              memwr;
  logic              nxm_clr;
  logic              mem_req;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;
  logic [31:0]       md;
  logic              mem_done;
  logic              busy;
  logic              nxm;

  int n_cmp;
  int n_err;

  vma_mem_port #(
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .vma_i       (vma),
    .md_in_i     (md_in),
    .memrd_i     (memrd),
    .memwr_i     (memwr),
    .nxm_clr_i   (nxm_clr),
    .mem_req_o   (mem_req),
    .mem_write_o (mem_write),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_ack_i   (mem_ack),
    .mem_rdata_i (mem_rdata),
    .md_o        (md),
    .mem_done_o  (mem_done),
    .busy_o      (busy),
    .nxm_o       (nxm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              rd, wr, clr, ack;
    logic [31:0]       vma, mdin, rdata;
    logic              req, wro;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata, md;
    logic              done, busy, nxm;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(
    input logic rd, input logic wr, input logic clr, input logic ack,
    input logic [31:0] v, input logic [31:0] mi, input logic [31:0] rdat,
    input logic req, input logic wro, input logic [ADDR_W-1:0] addr,
    input logic [31:0] wdat, input logic [31:0] m,
    input logic done, input logic bsy, input logic nx);
    vec_t e;
    e.rd = rd; e.wr = wr; e.clr = clr; e.ack = ack;
    e.vma = v; e.mdin = mi; e.rdata = rdat;
    e.req = req; e.wro = wro; e.addr = addr; e.wdata = wdat; e.md = m;
    e.done = done; e.busy = bsy; e.nxm = nx;
    vecs.push_back(e);
  endfunction

  function automatic logic [OUT_W-1:0] pack_out(
    input logic req, input logic wro, input logic [ADDR_W-1:0] addr,
    input logic [31:0] wdat, input logic [31:0] m,
    input logic done, input logic bsy, input logic nx);
    return {req, wro, addr, wdat, m, done, bsy, nx};
  endfunction

  task automatic check(input string name, input logic [OUT_W-1:0] got,
                       input logic [OUT_W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got {req,wr,addr,wdata,md,done,busy,nxm}=%h expected %h",
               name, got, exp);
    end
  endtask

  function automatic logic [OUT_W-1:0] dut_out();
    return pack_out(mem_req, mem_write, mem_addr, mem_wdata, md, mem_done, busy, nxm);
  endfunction

  task automatic drive(input logic rd, input logic wr, input logic clr, input logic ack,
                       input logic [31:0] v, input logic [31:0] mi, input logic [31:0] rdat);
    memrd = rd; memwr = wr; nxm_clr = clr; mem_ack = ack;
    vma = v; md_in = mi; mem_rdata = rdat;
  endtask

  localparam logic [31:0] DB = 32'hDEADBEEF;
  localparam logic [31:0] CF = 32'hCAFEF00D;
  localparam logic [31:0] M2 = 32'h02020202;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);

    // read, ack on 3rd REQ cycle
    add(1,0,0,0, 32'h00123456, 0, 0,           1,0,22'h123456, 0, 0,  0,1,0);
    add(0,0,0,0, 32'h00123456, 0, 0,           1,0,22'h123456, 0, 0,  0,1,0);
    add(0,0,0,0, 32'h00123456, 0, 0,           1,0,22'h123456, 0, 0,  0,1,0);
    add(0,0,0,1, 32'h00123456, 0, DB,          0,0,22'h123456, 0, DB, 1,0,0);
    add(0,0,0,0, 0, 0, 0,                      0,0,22'h123456, 0, DB, 0,0,0);
    // zero-wait write, rdata must not reach md
    add(0,1,0,0, 32'h003FFFFF, 32'hA5, 0,      1,1,22'h3FFFFF, 32'hA5, DB, 0,1,0);
    add(0,0,0,1, 32'h003FFFFF, 32'hA5, 32'h11111111, 0,1,22'h3FFFFF, 32'hA5, DB, 1,0,0);
    add(0,0,0,0, 0, 0, 0,                      0,1,22'h3FFFFF, 32'hA5, DB, 0,0,0);
    // rd+wr together: write wins; rd held during REQ is ignored
    add(1,1,0,0, 32'h100, 32'h5A, 0,           1,1,22'h100, 32'h5A, DB, 0,1,0);
    add(1,0,0,0, 32'h200, 0, 0,                1,1,22'h100, 32'h5A, DB, 0,1,0);
    add(1,0,0,1, 32'h200, 0, 32'h33333333,     0,1,22'h100, 32'h5A, DB, 1,0,0);
    add(1,0,0,0, 32'h200, 0, 0,                1,0,22'h200, 32'h5A, DB, 0,1,0);
    add(0,0,0,1, 32'h200, 0, CF,               0,0,22'h200, 32'h5A, CF, 1,0,0);
    // back-to-back zero-wait reads
    add(1,0,0,0, 32'h10, 0, 0,                 1,0,22'h10, 32'h5A, CF, 0,1,0);
    add(1,0,0,1, 32'h20, 0, 32'h01010101,      0,0,22'h10, 32'h5A, 32'h01010101, 1,0,0);
    add(1,0,0,0, 32'h20, 0, 0,                 1,0,22'h20, 32'h5A, 32'h01010101, 0,1,0);
    add(0,0,0,1, 32'h20, 0, M2,                0,0,22'h20, 32'h5A, M2, 1,0,0);
    add(0,0,0,0, 0, 0, 0,                      0,0,22'h20, 32'h5A, M2, 0,0,0);
    // timeout: req high exactly 4 cycles, nxm, then clear
    add(1,0,0,0, 32'h30, 0, 0,                 1,0,22'h30, 32'h5A, M2, 0,1,0);
    add(0,0,0,0, 0, 0, 0,                      1,0,22'h30, 32'h5A, M2, 0,1,0);
    add(0,0,0,0, 0, 0, 0,                      1,0,22'h30, 32'h5A, M2, 0,1,0);
    add(0,0,0,0, 0, 0, 0,                      1,0,22'h30, 32'h5A, M2, 0,1,0);
    add(0,0,0,0, 0, 0, 0,                      0,0,22'h30, 32'h5A, M2, 0,0,1);
    add(0,0,0,0, 0, 0, 0,                      0,0,22'h30, 32'h5A, M2, 0,0,1);
    add(0,0,1,0, 0, 0, 0,                      0,0,22'h30, 32'h5A, M2, 0,0,0);
    // ack on the final (4th) cycle completes normally
    add(0,1,0,0, 32'h40, 32'h77, 0,            1,1,22'h40, 32'h77, M2, 0,1,0);
    add(0,0,0,0, 0, 0, 0,                      1,1,22'h40, 32'h77, M2, 0,1,0);
    add(0,0,0,0, 0, 0, 0,                      1,1,22'h40, 32'h77, M2, 0,1,0);
    add(0,0,0,0, 0, 0, 0,                      1,1,22'h40, 32'h77, M2, 0,1,0);
    add(0,0,0,1, 0, 0, 32'h44444444,           0,1,22'h40, 32'h77, M2, 1,0,0);
    // abort coincident with nxm_clr: set wins
    add(1,0,0,0, 32'h50, 0, 0,                 1,0,22'h50, 32'h77, M2, 0,1,0);
    add(0,0,0,0, 0, 0, 0,                      1,0,22'h50, 32'h77, M2, 0,1,0);
    add(0,0,0,0, 0, 0, 0,                      1,0,22'h50, 32'h77, M2, 0,1,0);
    add(0,0,0,0, 0, 0, 0,                      1,0,22'h50, 32'h77, M2, 0,1,0);
    add(0,0,1,0, 0, 0, 0,                      0,0,22'h50, 32'h77, M2, 0,0,1);
    add(0,0,1,0, 0, 0, 0,                      0,0,22'h50, 32'h77, M2, 0,0,0);
    // stray ack while idle is ignored
    add(0,0,0,1, 0, 0, 32'h55555555,           0,0,22'h50, 32'h77, M2, 0,0,0);

    repeat (2) @(posedge clk);
    #1 check("reset_state", dut_out(), '0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rd, vecs[i].wr, vecs[i].clr, vecs[i].ack,
            vecs[i].vma, vecs[i].mdin, vecs[i].rdata);
      @(posedge clk);
      #1 check($sformatf("vec%0d", i), dut_out(),
               pack_out(vecs[i].req, vecs[i].wro, vecs[i].addr, vecs[i].wdata,
                        vecs[i].md, vecs[i].done, vecs[i].busy, vecs[i].nxm));
    end

    // asynchronous reset in the middle of an outstanding read
    @(negedge clk);
    drive(1, 0, 0, 0, 32'h60, 0, 0);
    @(posedge clk);
    #1 check("rst_pre_req", dut_out(),
             pack_out(1, 0, 22'h60, 32'h77, M2, 0, 1, 0));
    drive(0, 0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1 check("rst_async_clear", dut_out(), '0);
    mem_ack   = 1'b1;
    mem_rdata = 32'h66666666;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("rst_late_ack_ignored", dut_out(), '0);
    @(negedge clk);
    drive(1, 0, 0, 0, 32'h70, 0, 0);
    @(posedge clk);
    #1 check("post_rst_req", dut_out(),
             pack_out(1, 0, 22'h70, 0, 0, 0, 1, 0));
    @(negedge clk);
    drive(0, 0, 0, 1, 0, 0, 32'h12345678);
    @(posedge clk);
    #1 check("post_rst_done", dut_out(),
             pack_out(0, 0, 22'h70, 0, 32'h12345678, 1, 0, 0));
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vma_mem_port.md
# vma_mem_port

Memory-side responder for the CADR VMA register: it samples the virtual memory address and write data when the datapath starts a memory cycle, runs a req/ack handshake on the main memory bus, and returns read data into the MD register. It stalls the processor while a cycle is outstanding and flags non-existent memory (NXM) when the bus never acknowledges. It sits between the VMA/MD datapath registers and the memory bus arbiter.

## Interface

- ADDR_W, 22, physical address width driven on the bus; taken from vma[ADDR_W-1:0].
- TIMEOUT, 255, cycles mem_req may remain unacknowledged before the cycle aborts with NXM; legal range 2..65535.

- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- vma  in  32  current VMA register contents.
- md_in  in  32  write data from the datapath.
- memrd  in  1  start read cycle; sampled only when idle.
- memwr  in  1  start write cycle; sampled only when idle.
- nxm_clr  in  1  clears the sticky nxm flag.
- mem_req  out  1  bus request, held until ack or timeout.
- mem_write  out  1  1 = write cycle, valid while mem_req.
- mem_addr  out  ADDR_W  latched address.
- mem_wdata  out  32  latched write data.
- mem_ack  in  1  bus acknowledge; only meaningful while mem_req = 1.
- mem_rdata  in  32  read data, valid in the cycle mem_ack = 1 on a read.
- md  out  32  memory data register, updated on read completion.
- mem_done  out  1  one-cycle completion pulse (read or write, not on abort).
- busy  out  1  cycle outstanding; processor memory-wait.
- nxm  out  1  sticky non-existent-memory flag.

## Operation

- States: IDLE, REQ.
- IDLE: if memwr=1, latch mem_addr<=vma[ADDR_W-1:0], mem_wdata<=md_in, mem_write<=1, mem_req<=1, count<=0, go REQ. Else if memrd=1, same with mem_write<=0, mem_wdata unchanged. memrd and memwr both high: write wins, read discarded.
- REQ: busy=1; memrd/memwr ignored (not queued). mem_addr, mem_wdata, mem_write stable for the whole cycle.
- mem_ack=1 in REQ: mem_req<=0, mem_done<=1 for one cycle, go IDLE; if read, md<=mem_rdata.
- No ack: count<=count+1. If count==TIMEOUT-1 and no ack at that edge: mem_req<=0, nxm<=1, no mem_done, md unchanged, go IDLE. Ack on that final cycle wins over timeout.
- nxm: set by abort, cleared by nxm_clr; simultaneous set and clear → set wins.
- count width: ceil(log2(TIMEOUT)) bits; never wraps (reset on entry to REQ).
- Reset (any time, including mid-cycle): state IDLE; mem_req, mem_write, mem_done, busy, nxm, count = 0; mem_addr, mem_wdata, md = 0. In-flight cycle is dropped; a late mem_ack after reset is ignored.

## Timing

- Start sampled at edge E0; mem_req=1 and busy=1 from cycle after E0.
- Zero-wait bus: ack in first REQ cycle, sampled at E1; in the cycle after E1 mem_req=0, busy=0, mem_done=1, md valid. Minimum latency start→done: 2 edges.
- New start accepted in the same cycle mem_done=1 (back-to-back, one idle-free gap of zero cycles between req drop and re-raise is not allowed: mem_req is low for at least one cycle).
- busy is registered (equals state==REQ); no combinational path from mem_ack to any output.
- Abort: mem_req high for exactly TIMEOUT cycles, then low with nxm=1.

## Test plan

- Reset released, vma=0x0012_3456, memrd pulse, ack on 3rd REQ cycle with rdata=0xDEAD_BEEF → mem_addr=0x123456, mem_write=0, mem_req high 3 cycles, md=0xDEADBEEF, one mem_done pulse, busy low after.
- memwr with md_in=0x0000_00A5, vma=0x003F_FFFF, zero-wait ack → mem_write=1, mem_wdata=0xA5, mem_addr=0x3FFFFF, md unchanged, mem_done 1 cycle.
- memrd and memwr together, then memrd held during REQ → single write cycle only, no second request until IDLE.
- TIMEOUT=4, no ack → mem_req high exactly 4 cycles, nxm=1, no mem_done; ack on 4th cycle instead → completes normally, nxm=0; nxm_clr then clears a set flag.
- Back-to-back reads with zero-wait ack → mem_req low ≥1 cycle between, two mem_done pulses, md holds second rdata.
- Assert reset mid-REQ, then late mem_ack → all outputs 0 immediately (async), ack ignored, next memrd works normally.
